// File: rtl/jpeg_pixel_writer.sv
// ---------------------------------------------------------------------------
// jpeg_pixel_writer
//
// Pixel output stage between the JPEG decoder pixel port and a memory write
// port. Each accepted (x, y, r, g, b) beat is converted to the selected memory
// format and given its frame-buffer byte address. Neighbouring pixels that
// fall in the same DATA_W-wide word are combined into a single write with byte
// strobes.
//
// Pipeline:
//   S1 : registered format conversion, address computation and lane placement
//   P  : pending combining word (merges pixels that share a word address)
//   O  : output write register, held stable until wr_accept_i
//
// Parameters:
//   DATA_W   write data width in bits (32/64/128)
//   ADDR_W   byte address width
//   TIMEOUT  idle cycles before a partial pending word is pushed out (0 = off)
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   cfg_base_i              frame buffer base byte address
//   cfg_stride_i            bytes per line
//   cfg_fmt_i               0=XRGB8888, 1=RGB565, 2=GRAY8, 3=XRGB8888
//   flush_i                 single-cycle request to push out the pending word
//   inport_valid_i          pixel beat valid
//   inport_x_i, inport_y_i  pixel coordinates
//   inport_r_i/g_i/b_i      pixel colour
//   inport_accept_o         pixel beat accepted
//   wr_valid_o              write request valid
//   wr_addr_o               word-aligned byte address
//   wr_data_o               write data, little-endian byte lanes
//   wr_strb_o               byte enables
//   wr_accept_i             write accepted
//   idle_o                  S1, P and O all empty
// ---------------------------------------------------------------------------
module jpeg_pixel_writer #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic [ADDR_W-1:0]   cfg_base_i,
  input  logic [15:0]         cfg_stride_i,
  input  logic [1:0]          cfg_fmt_i,
  input  logic                flush_i,

  input  logic                inport_valid_i,
  input  logic [15:0]         inport_x_i,
  input  logic [15:0]         inport_y_i,
  input  logic [7:0]          inport_r_i,
  input  logic [7:0]          inport_g_i,
  input  logic [7:0]          inport_b_i,
  output logic                inport_accept_o,

  output logic                wr_valid_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o,
  input  logic                wr_accept_i,

  output logic                idle_o
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  // -------------------------------------------------------------------------
  // Pixel conversion (combinational, registered into S1)
  // -------------------------------------------------------------------------
  logic [31:0]       pix_word;
  logic [3:0]        pix_mask;
  logic [1:0]        bpp_log;
  logic [15:0]       gray_sum;
  logic [31:0]       row_off;
  logic [17:0]       col_off;
  logic [ADDR_W-1:0] byte_addr;
  logic [LANE_W-1:0] lane;
  logic [ADDR_W-1:0] in_word_addr;
  logic [DATA_W-1:0] in_data;
  logic [BYTES-1:0]  in_strb;

  // Format select: the unused encoding 3 falls back to XRGB8888.
  always_comb begin
    pix_word = '0;
    pix_mask = 4'b1111;
    bpp_log  = 2'd2;
    gray_sum = ({8'd0, inport_r_i} * 16'd77)
             + ({8'd0, inport_g_i} * 16'd150)
             + ({8'd0, inport_b_i} * 16'd29);
    case (cfg_fmt_i)
      2'd1: begin
        pix_word = {16'd0, inport_r_i[7:3], inport_g_i[7:2], inport_b_i[7:3]};
        pix_mask = 4'b0011;
        bpp_log  = 2'd1;
      end
      2'd2: begin
        // Weights sum to 256, so white maps to exactly 0xFF after the shift.
        pix_word = {24'd0, gray_sum[15:8]};
        pix_mask = 4'b0001;
        bpp_log  = 2'd0;
      end
      default: begin
        pix_word = {8'h00, inport_r_i, inport_g_i, inport_b_i};
        pix_mask = 4'b1111;
        bpp_log  = 2'd2;
      end
    endcase
  end

  // Frame buffer address and lane placement. Callers keep base and stride
  // aligned to the pixel size, so a pixel never straddles two words.
  always_comb begin
    row_off      = {16'd0, inport_y_i} * {16'd0, cfg_stride_i};
    col_off      = {2'b00, inport_x_i} << bpp_log;
    byte_addr    = cfg_base_i + ADDR_W'(row_off) + ADDR_W'(col_off);
    lane         = byte_addr[LANE_W-1:0];
    in_word_addr = {byte_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    in_data      = DATA_W'(pix_word) << {lane, 3'b000};
    in_strb      = BYTES'(pix_mask) << lane;
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic [BYTES-1:0]  s1_strb;

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;
  logic [BYTES-1:0]  p_strb;

  logic              o_valid;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  logic [BYTES-1:0]  o_strb;

  logic [CNT_W-1:0]  idle_cnt;

  // -------------------------------------------------------------------------
  // Combine / flush decisions
  // -------------------------------------------------------------------------
  logic o_free;
  logic can_merge;
  logic s1_blocked;
  logic timeout_hit;
  logic flush_req;
  logic do_flush;
  logic p_load;
  logic p_merge;
  logic s1_move;

  // A pixel merges only into the same word and only into bytes not yet
  // written; a repeated pixel therefore forces the older word out first.
  // When a flush and a load coincide, S1 always starts a fresh P word.
  always_comb begin
    o_free      = !o_valid || wr_accept_i;
    can_merge   = s1_valid && p_valid && (s1_addr == p_addr)
                  && ((s1_strb & p_strb) == '0);
    s1_blocked  = s1_valid && p_valid && !can_merge;
    timeout_hit = (TIMEOUT != 0) && (idle_cnt == CNT_LIMIT);
    flush_req   = p_valid && ((&p_strb) || s1_blocked || flush_i || timeout_hit);
    do_flush    = flush_req && o_free;
    p_load      = s1_valid && (!p_valid || do_flush);
    p_merge     = s1_valid && p_valid && !do_flush && can_merge;
    s1_move     = p_load || p_merge;
  end

  assign inport_accept_o = !s1_valid || s1_move;

  // S1 captures a new beat whenever it is empty or its content moves on.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      s1_strb  <= '0;
    end else if (inport_accept_o) begin
      s1_valid <= inport_valid_i;
      if (inport_valid_i) begin
        s1_addr <= in_word_addr;
        s1_data <= in_data;
        s1_strb <= in_strb;
      end
    end
  end

  // P either starts a new word from S1, absorbs S1 into its free bytes, or
  // empties when its word is handed to O with nothing to replace it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      p_data  <= '0;
      p_strb  <= '0;
    end else if (p_load) begin
      p_valid <= 1'b1;
      p_addr  <= s1_addr;
      p_data  <= s1_data;
      p_strb  <= s1_strb;
    end else if (p_merge) begin
      p_data  <= p_data | s1_data;
      p_strb  <= p_strb | s1_strb;
    end else if (do_flush) begin
      p_valid <= 1'b0;
    end
  end

  // O reloads in the same cycle it is accepted so words can issue
  // back-to-back; otherwise it holds until the write side accepts.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_data  <= '0;
      o_strb  <= '0;
    end else if (do_flush) begin
      o_valid <= 1'b1;
      o_addr  <= p_addr;
      o_data  <= p_data;
      o_strb  <= p_strb;
    end else if (wr_accept_i) begin
      o_valid <= 1'b0;
    end
  end

  // Counts cycles a partial word sits in P with no new pixel behind it.
  // Any activity on P restarts the count; it saturates at the limit so a
  // stalled O still sees the timeout once it frees up.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idle_cnt <= '0;
    end else if (p_load || p_merge || do_flush) begin
      idle_cnt <= '0;
    end else if (p_valid && !s1_valid && (idle_cnt != CNT_LIMIT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign wr_valid_o = o_valid;
  assign wr_addr_o  = o_addr;
  assign wr_data_o  = o_data;
  assign wr_strb_o  = o_strb;
  assign idle_o     = !s1_valid && !p_valid && !o_valid;

endmodule

// File: tb/tb_jpeg_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_jpeg_pixel_writer
//
// Directed bench for jpeg_pixel_writer (DATA_W=64, ADDR_W=32, TIMEOUT=15).
// Inputs change 1 ns after the rising edge; completed writes are logged at
// the rising edge where the handshake happens, and levels are checked on the
// falling edge.
//
// Ports: drives every input of the DUT and observes every output.
// ---------------------------------------------------------------------------
module tb_jpeg_pixel_writer;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk_i;
  logic              rst_i;
  logic [ADDR_W-1:0] cfg_base_i;
  logic [15:0]       cfg_stride_i;
  logic [1:0]        cfg_fmt_i;
  logic              flush_i;
  logic              inport_valid_i;
  logic [15:0]       inport_x_i;
  logic [15:0]       inport_y_i;
  logic [7:0]        inport_r_i;
  logic [7:0]        inport_g_i;
  logic [7:0]        inport_b_i;
  logic              inport_accept_o;
  logic              wr_valid_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [7:0]        wr_strb_o;
  logic              wr_accept_i;
  logic              idle_o;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [7:0]        strb;
  } wr_t;

  wr_t wr_q[$];
  wr_t wr_item;

  int assert_count = 0;
  int fail_count   = 0;

  jpeg_pixel_writer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_base_i     (cfg_base_i),
    .cfg_stride_i   (cfg_stride_i),
    .cfg_fmt_i      (cfg_fmt_i),
    .flush_i        (flush_i),
    .inport_valid_i (inport_valid_i),
    .inport_x_i     (inport_x_i),
    .inport_y_i     (inport_y_i),
    .inport_r_i     (inport_r_i),
    .inport_g_i     (inport_g_i),
    .inport_b_i     (inport_b_i),
    .inport_accept_o(inport_accept_o),
    .wr_valid_o     (wr_valid_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .wr_strb_o      (wr_strb_o),
    .wr_accept_i    (wr_accept_i),
    .idle_o         (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Log every write handshake in issue order.
  always @(posedge clk_i) begin
    if (rst_i && wr_valid_o && wr_accept_i)
      wr_q.push_back('{wr_addr_o, wr_data_o, wr_strb_o});
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one pixel and hold it until accepted (bounded).
  task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y,
                                input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b);
    logic acc;
    int   cyc;
    inport_valid_i = 1'b1;
    inport_x_i     = x;
    inport_y_i     = y;
    inport_r_i     = r;
    inport_g_i     = g;
    inport_b_i     = b;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 200) begin
      @(negedge clk_i);
      acc = inport_accept_o;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    inport_valid_i = 1'b0;
    check_output("pixel_accept", 128'(acc), 128'd1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (wr_q.size() < n && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
    end
    check_output("write_count", 128'(wr_q.size()), 128'(n));
  endtask

  task automatic wait_idle(input int budget);
    int cyc;
    cyc = 0;
    @(negedge clk_i);
    while (!idle_o && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
    end
    check_output("drain_idle", 128'(idle_o), 128'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input logic [7:0] strb);
    wr_t w;
    if (wr_q.size() == 0) begin
      check_output({tag, "_present"}, 128'd0, 128'd1);
    end else begin
      w = wr_q.pop_front();
      check_output({tag, "_addr"}, 128'(w.addr), 128'(addr));
      check_output({tag, "_strb"}, 128'(w.strb), 128'(strb));
      check_output({tag, "_data"}, 128'(w.data), 128'(data));
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    cfg_base_i     = 32'h0000_1000;
    cfg_stride_i   = 16'd64;
    cfg_fmt_i      = 2'd0;
    flush_i        = 1'b0;
    inport_valid_i = 1'b0;
    inport_x_i     = '0;
    inport_y_i     = '0;
    inport_r_i     = '0;
    inport_g_i     = '0;
    inport_b_i     = '0;
    wr_accept_i    = 1'b1;

    // ---- reset state ----
    #2 rst_i = 1'b0;
    #1;
    check_output("rst_wr_valid", 128'(wr_valid_o), 128'd0);
    check_output("rst_wr_addr", 128'(wr_addr_o), 128'd0);
    check_output("rst_wr_data", 128'(wr_data_o), 128'd0);
    check_output("rst_wr_strb", 128'(wr_strb_o), 128'd0);
    check_output("rst_idle", 128'(idle_o), 128'd1);
    check_output("rst_accept", 128'(inport_accept_o), 128'd1);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // ---- XRGB8888: two pixels fill one 64-bit word ----
    $display("[TB] XRGB8888 word merge");
    apply_stimulus(16'd0, 16'd0, 8'h11, 8'h22, 8'h33);
    apply_stimulus(16'd1, 16'd0, 8'h11, 8'h22, 8'h33);
    wait_writes(1, 10);
    check_write("xrgb", 32'h0000_1000, 64'h0011_2233_0011_2233, 8'hFF);
    wait_idle(20);

    // ---- RGB565: four halfwords on line 1 ----
    $display("[TB] RGB565 line 1");
    cfg_fmt_i = 2'd1;
    for (int i = 0; i < 4; i++)
      apply_stimulus(16'(i), 16'd1, 8'hFF, 8'h00, 8'hFF);
    wait_writes(1, 10);
    check_write("rgb565", 32'h0000_1040, 64'hF81F_F81F_F81F_F81F, 8'hFF);
    wait_idle(20);

    // ---- GRAY8: lone pixel pushed out by the idle timeout ----
    $display("[TB] GRAY8 timeout flush");
    cfg_fmt_i = 2'd2;
    apply_stimulus(16'd5, 16'd0, 8'hFF, 8'hFF, 8'hFF);
    repeat (17) @(negedge clk_i);
    check_output("gray_not_early", 128'(wr_valid_o), 128'd0);
    check_output("gray_busy", 128'(idle_o), 128'd0);
    @(negedge clk_i);
    check_output("gray_on_time", 128'(wr_valid_o), 128'd1);
    wait_writes(1, 5);
    check_write("gray", 32'h0000_1000, 64'h0000_FF00_0000_0000, 8'h20);
    wait_idle(20);

    // ---- back-pressure: 16 XRGB pixels while writes are refused ----
    $display("[TB] back-pressure");
    cfg_fmt_i   = 2'd0;
    cfg_base_i  = 32'h0000_2000;
    wr_accept_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++)
          apply_stimulus(16'(i), 16'd0, 8'(i), 8'h40, 8'(8'hA0 + i));
      end
      begin
        repeat (20) @(negedge clk_i);
        check_output("bp_accept_low", 128'(inport_accept_o), 128'd0);
        check_output("bp_wr_valid", 128'(wr_valid_o), 128'd1);
        check_output("bp_wr_addr_hold", 128'(wr_addr_o), 128'h2000);
        check_output("bp_no_write", 128'(wr_q.size()), 128'd0);
        @(posedge clk_i);
        #1 wr_accept_i = 1'b1;
      end
    join
    wait_writes(8, 100);
    for (int k = 0; k < 8; k++)
      check_write("bp_word", 32'h0000_2000 + 32'(8 * k),
                  {8'h00, 8'(2 * k + 1), 8'h40, 8'(8'hA1 + 2 * k),
                   8'h00, 8'(2 * k), 8'h40, 8'(8'hA0 + 2 * k)}, 8'hFF);
    wait_idle(20);

    // ---- repeated pixel: older colour first, second pushed by flush_i ----
    $display("[TB] repeated pixel and flush");
    cfg_base_i = 32'h0000_1000;
    apply_stimulus(16'd0, 16'd0, 8'h01, 8'h02, 8'h03);
    apply_stimulus(16'd0, 16'd0, 8'h04, 8'h05, 8'h06);
    @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    wait_writes(2, 3);
    check_write("dup_first", 32'h0000_1000, 64'h0000_0000_0001_0203, 8'h0F);
    check_write("dup_second", 32'h0000_1000, 64'h0000_0000_0004_0506, 8'h0F);
    wait_idle(20);

    // ---- flush_i with nothing pending ----
    $display("[TB] flush while empty");
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check_output("empty_flush_valid", 128'(wr_valid_o), 128'd0);
    check_output("empty_flush_count", 128'(wr_q.size()), 128'd0);
    @(posedge clk_i);
    #1;

    // ---- reset with P and O both occupied ----
    $display("[TB] reset mid-operation");
    wr_accept_i = 1'b0;
    apply_stimulus(16'd0, 16'd0, 8'hAA, 8'hBB, 8'hCC);
    apply_stimulus(16'd1, 16'd0, 8'hAA, 8'hBB, 8'hCC);
    apply_stimulus(16'd0, 16'd1, 8'hAA, 8'hBB, 8'hCC);
    repeat (3) @(posedge clk_i);
    #1;
    check_output("mid_wr_valid", 128'(wr_valid_o), 128'd1);
    check_output("mid_busy", 128'(idle_o), 128'd0);
    rst_i = 1'b0;
    #1;
    check_output("mid_rst_valid", 128'(wr_valid_o), 128'd0);
    check_output("mid_rst_idle", 128'(idle_o), 128'd1);
    check_output("mid_rst_strb", 128'(wr_strb_o), 128'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i       = 1'b1;
    wr_accept_i = 1'b1;
    repeat (25) @(negedge clk_i);
    check_output("post_rst_no_write", 128'(wr_q.size()), 128'd0);
    check_output("post_rst_idle", 128'(idle_o), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/jpeg_pixel_writer.md
Name: jpeg_pixel_writer

Overview:
- Parametrised successor to the core's fixed RGB888 pixel output stage.
- Accepts per-pixel (x, y, r, g, b) beats from the decoder output in MCU order.
- Converts each pixel to a selectable memory format, computes its frame-buffer byte address, and merges adjacent pixels into DATA_W-wide write words with byte strobes.
- Sits between the decoder pixel port and a memory write port.

Parameters:
- DATA_W, 64, write data width in bits; legal values 32/64/128.
- ADDR_W, 32, byte address width.
- TIMEOUT, 15, idle cycles before a partial pending word is flushed; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- cfg_base_i  in  ADDR_W  frame buffer base byte address
- cfg_stride_i  in  16  bytes per line
- cfg_fmt_i  in  2  0=XRGB8888, 1=RGB565, 2=GRAY8, 3=treated as 0
- flush_i  in  1  single-cycle pulse; force out the pending word
- inport_valid_i  in  1  pixel valid
- inport_x_i  in  16  pixel x
- inport_y_i  in  16  pixel y
- inport_r_i / inport_g_i / inport_b_i  in  8 each  pixel colour
- inport_accept_o  out  1  pixel accepted
- wr_valid_o  out  1  write request valid
- wr_addr_o  out  ADDR_W  word-aligned byte address
- wr_data_o  out  DATA_W  write data, little-endian bytes
- wr_strb_o  out  DATA_W/8  byte enables
- wr_accept_i  in  1  write accepted
- idle_o  out  1  all stages empty

Behaviour:
- Reset: all valids 0, wr_addr/data/strb 0, idle_o 1, idle counter 0. Reset mid-operation discards all pending data.
- Config is sampled per pixel in stage 1; it must be stable while idle_o=0.
- Stage 1 (S1), registered conversion:
  - Byte offset = cfg_base + y*cfg_stride + x*bpp, where bpp = 4/2/1.
  - XRGB8888 = {8'h00, r, g, b}.
  - RGB565 = {r[7:3], g[7:2], b[7:3]}.
  - GRAY8 = (77r + 150g + 29b) >> 8, computed in 16-bit, truncated.
  - Pixel bytes are placed at lane offset[log2(DATA_W/8)-1:0]; the strobe marks bpp bytes. A pixel never straddles a word.
- inport_accept_o = !S1_valid || S1 moves to pending this cycle.
- Pending word (P), combining register. When S1 is valid:
  - P empty: load S1.
  - P valid, same word address, no strobe overlap: merge data bytes and OR strobes into P.
  - Otherwise P must flush first; S1 loads into P in that same flush cycle.
- Flush P into the output register (O) when O is empty or is accepted this cycle, and any of:
  - P strobe is all ones;
  - S1 cannot merge;
  - flush_i is high;
  - idle counter == TIMEOUT (TIMEOUT != 0).
- Simultaneous flush and load: P goes to O and S1 goes to P in the same cycle. Word order is strictly preserved.
- An overlapping byte (same pixel written twice) never merges: the older word is issued first.
- Idle counter:
  - Increments while P is valid and S1 is empty.
  - Clears on any P load, merge or flush.
  - Saturates at TIMEOUT.
- O holds wr_valid_o, wr_addr_o, wr_data_o and wr_strb_o stable until wr_accept_i. Back-to-back issue is allowed: O reloads in the same cycle it is accepted.
- If O is stalled, P keeps merging; S1 stalls only when P needs to flush and cannot.
- Latency: a pixel accepted at cycle N is in P at N+2. A flush triggered at cycle M gives wr_valid_o at M+1.
- flush_i with P empty: no effect.
- idle_o = !S1_valid && !P_valid && !wr_valid_o.

Test Plan:
- XRGB8888, DATA_W=64, base=0x1000, stride=64: pixels (0,0) and (1,0), r=0x11 g=0x22 b=0x33 -> one write, addr 0x1000, strb 0xFF, data 0x00112233_00112233.
- RGB565, pixels x=0..3 on y=1, colour (0xFF,0x00,0xFF) -> one write, addr base+64, strb 0xFF, each halfword 0xF81F.
- GRAY8, single pixel (5,0), colour (255,255,255), then no further input -> after TIMEOUT=15 idle cycles, write at addr base, strb 0x20, byte5 0xFF. Luma must be 255.
- wr_accept_i held low for 20 cycles while 16 pixels stream -> no loss or reorder, inport_accept_o deasserts, all words emitted in address order once accept returns.
- Same pixel (0,0) sent twice with different colours -> two writes, the first colour issued first.
- Reset asserted (rst_i=0) with P and O valid -> wr_valid_o=0, idle_o=1 immediately; no write after release.
